// File: rtl/line_raster_gen.sv
// Line raster generator: 1-bit-per-cell bitmap, Bresenham line engine and
// a two-stage scan-out pipeline driven by the VGA sync stage.
module line_raster_gen #(
  parameter int               GRID_W      = 160,
  parameter int               GRID_H      = 120,
  parameter int               SCALE_SHIFT = 2,
  parameter int               RGB_W       = 12,
  parameter logic [RGB_W-1:0] FG_RGB      = 12'hFFF,
  parameter logic [RGB_W-1:0] BG_RGB      = 12'h000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [7:0]       x0,
  input  logic [7:0]       x1,
  input  logic [7:0]       y0,
  input  logic [7:0]       y1,
  output logic             busy,
  output logic             done,
  input  logic [9:0]       pixel_x,
  input  logic [9:0]       pixel_y,
  input  logic             video_on,
  output logic [RGB_W-1:0] rgb
);

  localparam int             CELLS  = GRID_W * GRID_H;
  localparam int             AW     = $clog2(CELLS);
  localparam logic [7:0]     XMAX   = 8'(GRID_W - 1);
  localparam logic [7:0]     YMAX   = 8'(GRID_H - 1);
  localparam logic [AW-1:0]  LAST   = AW'(CELLS - 1);
  localparam logic [9:0]     SCAN_W = 10'(GRID_W << SCALE_SHIFT);
  localparam logic [9:0]     SCAN_H = 10'(GRID_H << SCALE_SHIFT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETUP,
    S_DRAW,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            ex0_q, ex0_d, ey0_q, ey0_d;
  logic [7:0]            ex1_q, ex1_d, ey1_q, ey1_d;
  logic [AW-1:0]         clr_q, clr_d;
  logic signed [9:0]     cx_q, cx_d, cy_q, cy_d;
  logic signed [9:0]     err_q, err_d;
  logic signed [9:0]     dx_q, dx_d, dy_q, dy_d;
  logic signed [9:0]     sx_q, sx_d, sy_q, sy_d;

  logic signed [9:0]     px0, py0, px1, py1, dxv, dyv, err_n;
  logic signed [10:0]    e2, dx_w, dy_w;

  logic                  we, wdata;
  logic [AW-1:0]         waddr;

  logic                  mem [CELLS];
  logic                  cell_q;
  logic                  in_grid;
  logic [AW-1:0]         rd_addr;
  logic                  vid_q, vid_d, ing_q, ing_d;
  logic [RGB_W-1:0]      rgb_q, rgb_d;

  // Engine next-state, datapath update and bitmap write port
  always_comb begin
    state_d = state_q;
    ex0_d   = ex0_q;
    ey0_d   = ey0_q;
    ex1_d   = ex1_q;
    ey1_d   = ey1_q;
    clr_d   = clr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    err_d   = err_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    we      = 1'b0;
    wdata   = 1'b0;
    waddr   = '0;
    px0     = $signed({2'b00, ex0_q});
    py0     = $signed({2'b00, ey0_q});
    px1     = $signed({2'b00, ex1_q});
    py1     = $signed({2'b00, ey1_q});
    dxv     = '0;
    dyv     = '0;
    err_n   = err_q;
    e2      = {err_q, 1'b0};
    dx_w    = {dx_q[9], dx_q};
    dy_w    = {dy_q[9], dy_q};
    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          clr_d   = '0;
        end else if (start) begin
          state_d = S_SETUP;
          ex0_d   = (x0 > XMAX) ? XMAX : x0;
          ey0_d   = (y0 > YMAX) ? YMAX : y0;
          ex1_d   = (x1 > XMAX) ? XMAX : x1;
          ey1_d   = (y1 > YMAX) ? YMAX : y1;
        end
      end
      S_CLEAR: begin
        we    = 1'b1;
        waddr = clr_q;
        if (clr_q == LAST) state_d = S_DONE;
        else               clr_d   = clr_q + 1'b1;
      end
      S_SETUP: begin
        dxv     = px1 - px0;
        dyv     = py1 - py0;
        dx_d    = (dxv < 0) ? -dxv : dxv;
        dy_d    = (dyv < 0) ? dyv : -dyv;
        sx_d    = (px0 < px1) ? 10'sd1 : -10'sd1;
        sy_d    = (py0 < py1) ? 10'sd1 : -10'sd1;
        err_d   = dx_d + dy_d;
        cx_d    = px0;
        cy_d    = py0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        we    = 1'b1;
        wdata = 1'b1;
        waddr = AW'(cy_q[7:0]) * AW'(GRID_W) + AW'(cx_q[7:0]);
        if (cx_q == px1 && cy_q == py1) begin
          state_d = S_DONE;
        end else begin
          // Both tests use the error term from before this step
          if (e2 >= dy_w) begin
            err_n = err_n + dy_q;
            cx_d  = cx_q + sx_q;
          end
          if (e2 <= dx_w) begin
            err_n = err_n + dx_q;
            cy_d  = cy_q + sy_q;
          end
          err_d = err_n;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Engine registers; reset aborts any draw or clear in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ex0_q   <= '0;
      ey0_q   <= '0;
      ex1_q   <= '0;
      ey1_q   <= '0;
      clr_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      err_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      ex0_q   <= ex0_d;
      ey0_q   <= ey0_d;
      ex1_q   <= ex1_d;
      ey1_q   <= ey1_d;
      clr_q   <= clr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // Scan stage 1 address: cell under the current screen pixel
  always_comb begin
    in_grid = (pixel_x < SCAN_W) && (pixel_y < SCAN_H);
    rd_addr = AW'(pixel_y >> SCALE_SHIFT) * AW'(GRID_W) + AW'(pixel_x >> SCALE_SHIFT);
    vid_d   = video_on;
    ing_d   = in_grid;
    rgb_d   = (vid_q && ing_q) ? (cell_q ? FG_RGB : BG_RGB) : '0;
  end

  // Bitmap RAM: one write port, one synchronous read port (read-before-write)
  always_ff @(posedge clk) begin
    if (we)      mem[waddr] <= wdata;
    if (in_grid) cell_q     <= mem[rd_addr];
  end

  // Scan pipeline registers: video/in-grid flags alongside the read, then colour
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_q <= 1'b0;
      ing_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      vid_q <= vid_d;
      ing_q <= ing_d;
      rgb_q <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule
